pc_fetch_step_1: RTL

Step-1 fetch block for the four-step pipeline. It holds the program counter, applies the next-PC select produced by the step-1 control FSM (`control_mux_for_PC`), and honours the hazard stall. It owns the step-1/step-2 pipeline register that carries instruction, PC+4 and a valid bit, and inserts a bubble on every taken redirect. The block is the consumer end of the `control_mux_for_PC` interface.

---
 rtl/pc_fetch_step_1.sv | 105 ++++++++++
 1 files changed

// File: rtl/pc_fetch_step_1.sv
// Step-1 fetch: program counter, next-PC select, hazard stall and the step-1/step-2 register.
// Optional redirect counter on output redirect_count when PC_REDIRECT_COUNT_EN is defined.
module pc_fetch_step_1 #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  control_mux_for_PC,
    input  logic [31:0] branch_target_step_4,
    input  logic [31:0] jump_target_step_4,
    input  logic        is_hazzard,
    input  logic [31:0] instr_rdata,
    output logic [31:0] pc,
    output logic [31:0] instr_step_2,
    output logic [31:0] pc_plus_4_step_2,
    output logic        valid_step_2,
    output logic        flush_younger,
    output logic        sel_error
`ifdef PC_REDIRECT_COUNT_EN
    ,
    output logic [15:0] redirect_count
`endif
);

    typedef enum logic [1:0] {
        SEL_SEQ = 2'b00,
        SEL_BR  = 2'b01,
        SEL_JMP = 2'b10,
        SEL_ILL = 2'b11
    } sel_e;

    sel_e        sel;
    logic        redirect;
    logic [31:0] pc_inc;
    logic [31:0] pc_d, pc_q;
    logic [31:0] instr_d, instr_q;
    logic [31:0] pc4_d, pc4_q;
    logic        valid_d, valid_q;
    logic        err_d, err_q;

    assign sel      = sel_e'(control_mux_for_PC);
    assign redirect = (sel == SEL_BR) || (sel == SEL_JMP);
    assign pc_inc   = pc_q + 32'd4;

    // Redirect outranks the stall: the stalled instruction is on the wrong path.
    always_comb begin
        pc_d    = pc_inc;
        instr_d = instr_rdata;
        pc4_d   = pc_inc;
        valid_d = 1'b1;
        err_d   = err_q | (sel == SEL_ILL);
        if (redirect) begin
            pc_d    = (sel == SEL_BR) ? {branch_target_step_4[31:2], 2'b00}
                                      : {jump_target_step_4[31:2], 2'b00};
            instr_d = 32'h0;
            pc4_d   = pc4_q;
            valid_d = 1'b0;
        end else if (is_hazzard) begin
            pc_d    = pc_q;
            instr_d = instr_q;
            pc4_d   = pc4_q;
            valid_d = valid_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            instr_q <= 32'h0;
            pc4_q   <= 32'h0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

`ifdef PC_REDIRECT_COUNT_EN
    logic [15:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (redirect && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= 16'h0;
        else     cnt_q <= cnt_d;
    end

    assign redirect_count = cnt_q;
`endif

    assign pc               = pc_q;
    assign instr_step_2     = instr_q;
    assign pc_plus_4_step_2 = pc4_q;
    assign valid_step_2     = valid_q;
    assign flush_younger    = redirect;
    assign sel_error        = err_q;

endmodule
